pwm_ramp_sequencer: RTL and testbench
=====================================

Name: pwm_ramp_sequencer

Overview:
Controller that sequences the duty-cycle input of the 8-bit PWM core. It accepts a target duty over a valid/ready handshake. It then ramps its duty output from the present value to the target in fixed steps, advancing one step every (cfg_dwell+1) PWM periods. Duty changes only at PWM period boundaries, so the PWM output never sees a mid-period glitch.

Parameters:
WIDTH, 8, duty width; matches the PWM core's duty input.
DWELL_W, 8, width of the dwell (periods-per-step) counter.

Ports:
clk  in  1  clock
rst_i  in  1  reset
en  in  1  sequencer enable; low pauses everything
period_tick  in  1  one-cycle pulse from the PWM core at the start of each PWM period
tgt_valid  in  1  target request valid
tgt_ready  out  1  target request accepted when valid&ready
tgt_duty  in  WIDTH  requested final duty
cfg_step  in  WIDTH  duty increment per step; 0 is treated as 1
cfg_dwell  in  DWELL_W  extra periods between steps (0 = step every period)
abort  in  1  stop ramp and keep the current duty
duty_o  out  WIDTH  duty value driven to the PWM core
busy  out  1  ramp in progress
done  out  1  one-cycle pulse when duty_o reaches the target

Behaviour:
- Reset: rst_i is asynchronous, active-high; clock is clk. Reset forces duty_o=0, state=IDLE, busy=0, done=0, dwell counter=0 and latched target=0. Reset mid-ramp drops duty_o to 0 immediately.
- tgt_ready = en & (state==IDLE) & ~abort. It is combinational and is 0 during reset.
- States: IDLE, UP, DOWN, DONE.
- IDLE, on accept (tgt_valid&tgt_ready):
  - Latch tgt_duty, cfg_step (0 is stored as 1) and cfg_dwell.
  - Clear the dwell counter.
  - If target>duty_o go to UP; if target<duty_o go to DOWN; if equal go to DONE.
- UP/DOWN:
  - busy=1.
  - On each period_tick with en=1: if dwell_cnt==dwell_lat, apply one step and clear dwell_cnt; otherwise increment dwell_cnt.
  - A period_tick in the accept cycle is ignored.
- Step arithmetic is computed in WIDTH+1 bits and saturates at the target, never overshooting:
  - UP: duty_o <= (tgt-duty_o <= step) ? tgt : duty_o+step.
  - DOWN: duty_o <= (duty_o-tgt <= step) ? tgt : duty_o-step.
  - Cannot wrap below 0 or above 2^WIDTH-1.
- The cycle after duty_o equals the target, the FSM enters DONE.
- DONE: done=1 for exactly one cycle and busy=0, then IDLE. Only one done pulse per request.
- Latency:
  - First step lands on the (dwell+1)-th period_tick after accept.
  - duty_o updates in the same clock edge that samples period_tick.
- en=0 in UP/DOWN: freezes duty_o and dwell_cnt; period_ticks are ignored. Resumes in place when en returns.
- abort=1 in UP/DOWN: next state is IDLE with duty_o held, no done pulse, and dwell_cnt cleared.
  - abort in the same cycle as a stepping period_tick: abort wins and no step is applied.
- abort and tgt_valid together in IDLE: no accept, because ready=0.
- cfg_* and tgt_duty changes after accept have no effect until the next request.

Decomposition:
- Shared package pwm_seq_pkg holds:
  - the state encoding (IDLE/UP/DOWN/DONE, 2 bits);
  - default WIDTH=8 and DWELL_W=8 constants.
- One natural sub-module: pwm_dwell_counter. It takes clk, rst_i, clr, tick_en and limit, and outputs step_due, a registered count compare. The top keeps the FSM and the step/saturation datapath.

Test Plan:
- Reset mid-ramp: rst_i pulsed asynchronously during UP at duty 40 -> duty_o=0, busy=0 before the next clk edge; tgt_ready=1 once en=1.
- Basic up-ramp: duty 0, target 100, step 25, dwell 0; four period_ticks -> duty 25,50,75,100, then one done pulse, busy falls.
- Saturation and dwell: duty 200, target 10, step 64, dwell 2 -> duty 136 after the 3rd tick, 72 after the 6th, 10 after the 9th (no underflow wrap); exactly one done.
- Edge values: target equal to current duty (50->50) -> done on the next cycle with no duty change. step=0 from 0 to 3 -> increments of 1 per tick. Target 255 with step 200 -> 200 then 255, no wrap.
- Pause/abort: en low for 5 ticks mid-UP at duty 60 -> duty stays 60, resumes on the correct dwell count. abort coinciding with a stepping tick -> duty unchanged, IDLE, no done.
- Handshake: tgt_valid held while busy -> tgt_ready=0, no accept; a second request accepted only after the done cycle. Changing tgt_duty mid-ramp is ignored.

Source files
------------

// File: rtl/pwm_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pwm_seq_pkg
// Brief    : Shared state encoding and default widths for the PWM ramp sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package pwm_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_UP   = 2'd1,
        ST_DOWN = 2'd2,
        ST_DONE = 2'd3
    } seq_state_t;

    localparam int c_default_width   = 8;
    localparam int c_default_dwell_w = 8;

endpackage
`default_nettype wire

// File: rtl/pwm_dwell_counter.sv
`default_nettype none
// ============================================================================
// Module   : pwm_dwell_counter
// Brief    : Counts qualified period ticks and flags when the next one should step.
// Revision : 1.0 - initial release
// ============================================================================
module pwm_dwell_counter
    import pwm_seq_pkg::*;
#(
    parameter int DWELL_W = c_default_dwell_w
) (
    input  logic               clk,
    input  logic               rst_i,
    input  logic               clr,
    input  logic               tick_en,
    input  logic [DWELL_W-1:0] limit,
    output logic               step_due
);

    logic [DWELL_W-1:0] r_cnt;

    assign step_due = (r_cnt == limit);

    // Wraps back to zero on the tick that produces a step.
    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (tick_en) begin
            r_cnt <= step_due ? '0 : r_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/pwm_ramp_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pwm_ramp_sequencer
// Brief    : Ramps the PWM duty toward a requested target, stepping only on period ticks.
// Revision : 1.0 - initial release
// ============================================================================
module pwm_ramp_sequencer
    import pwm_seq_pkg::*;
#(
    parameter int WIDTH   = c_default_width,
    parameter int DWELL_W = c_default_dwell_w
) (
    input  logic               clk,
    input  logic               rst_i,
    input  logic               en,
    input  logic               period_tick,
    input  logic               tgt_valid,
    output logic               tgt_ready,
    input  logic [WIDTH-1:0]   tgt_duty,
    input  logic [WIDTH-1:0]   cfg_step,
    input  logic [DWELL_W-1:0] cfg_dwell,
    input  logic               abort,
    output logic [WIDTH-1:0]   duty_o,
    output logic               busy,
    output logic               done
);

    seq_state_t         r_state;
    logic [WIDTH-1:0]   r_duty;
    logic [WIDTH-1:0]   r_tgt;
    logic [WIDTH-1:0]   r_step;
    logic [DWELL_W-1:0] r_dwell;
    logic               r_busy;
    logic               r_done;

    logic               w_accept;
    logic               w_ramping;
    logic               w_at_tgt;
    logic               w_tick_en;
    logic               w_step_due;
    logic               w_dwell_clr;
    logic [WIDTH:0]     w_gap;
    logic [WIDTH-1:0]   w_stepped;
    logic [WIDTH-1:0]   w_next_duty;

    assign tgt_ready   = en & ~abort & ~rst_i & (r_state == ST_IDLE);
    assign w_accept    = tgt_valid & tgt_ready;
    assign w_ramping   = (r_state == ST_UP) | (r_state == ST_DOWN);
    assign w_at_tgt    = (r_duty == r_tgt);
    assign w_tick_en   = w_ramping & en & period_tick & ~abort & ~w_at_tgt;
    assign w_dwell_clr = w_accept | (w_ramping & abort);

    // Distance to target is one bit wider so the saturation test never wraps;
    // once the gap exceeds the step, the plain add/subtract cannot overflow.
    assign w_gap       = (r_state == ST_DOWN) ? ({1'b0, r_duty} - {1'b0, r_tgt})
                                              : ({1'b0, r_tgt} - {1'b0, r_duty});
    assign w_stepped   = (r_state == ST_DOWN) ? (r_duty - r_step) : (r_duty + r_step);
    assign w_next_duty = (w_gap <= {1'b0, r_step}) ? r_tgt : w_stepped;

    pwm_dwell_counter #(
        .DWELL_W (DWELL_W)
    ) u_dwell (
        .clk      (clk),
        .rst_i    (rst_i),
        .clr      (w_dwell_clr),
        .tick_en  (w_tick_en),
        .limit    (r_dwell),
        .step_due (w_step_due)
    );

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
            r_duty  <= '0;
            r_tgt   <= '0;
            r_step  <= '0;
            r_dwell <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_tgt   <= tgt_duty;
                        r_step  <= (cfg_step == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : cfg_step;
                        r_dwell <= cfg_dwell;
                        if (tgt_duty > r_duty) begin
                            r_state <= ST_UP;
                            r_busy  <= 1'b1;
                        end else if (tgt_duty < r_duty) begin
                            r_state <= ST_DOWN;
                            r_busy  <= 1'b1;
                        end else begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                ST_UP, ST_DOWN: begin
                    if (abort) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else if (en) begin
                        if (w_at_tgt) begin
                            r_state <= ST_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else if (w_tick_en && w_step_due) begin
                            r_duty <= w_next_duty;
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign duty_o = r_duty;
    assign busy   = r_busy;
    assign done   = r_done;

endmodule
`default_nettype wire

// File: tb/tb_pwm_ramp_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pwm_ramp_sequencer
// Brief    : Directed scoreboard bench; expected duty changes and done pulses queued in order.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pwm_ramp_sequencer;

    logic       clk;
    logic       rst_i;
    logic       en;
    logic       period_tick;
    logic       tgt_valid;
    logic       tgt_ready;
    logic [7:0] tgt_duty;
    logic [7:0] cfg_step;
    logic [7:0] cfg_dwell;
    logic       abort;
    logic [7:0] duty_o;
    logic       busy;
    logic       done;

    int n_checks = 0;
    int n_pass   = 0;
    int exp_q[$];          // expected events: duty value, or -1 for a done pulse

    pwm_ramp_sequencer #(.WIDTH(8), .DWELL_W(8)) dut (
        .clk         (clk),
        .rst_i       (rst_i),
        .en          (en),
        .period_tick (period_tick),
        .tgt_valid   (tgt_valid),
        .tgt_ready   (tgt_ready),
        .tgt_duty    (tgt_duty),
        .cfg_step    (cfg_step),
        .cfg_dwell   (cfg_dwell),
        .abort       (abort),
        .duty_o      (duty_o),
        .busy        (busy),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic sb_check(input string name, input int got);
        int e;
        if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL %s: got %0d expected no event", name, got);
        end else begin
            e = exp_q.pop_front();
            chk(name, got, e);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_ticks(input int n);
        repeat (n) begin
            period_tick = 1'b1;
            cyc(1);
            period_tick = 1'b0;
            cyc(2);
        end
    endtask

    task automatic request(input int t, input int s, input int d);
        int waited;
        waited    = 0;
        tgt_duty  = 8'(t);
        cfg_step  = 8'(s);
        cfg_dwell = 8'(d);
        tgt_valid = 1'b1;
        while (!tgt_ready && waited < 20) begin
            cyc(1);
            waited++;
        end
        if (!tgt_ready) chk("ready_timeout", int'(tgt_ready), 1);
        cyc(1);
        tgt_valid = 1'b0;
    endtask

    // Monitor: every observed duty change or done pulse must match the queue head.
    initial begin : monitor
        int prev;
        prev = 0;
        forever begin
            @(negedge clk);
            if (int'(duty_o) != prev) begin
                prev = int'(duty_o);
                sb_check("duty_event", prev);
            end
            if (done === 1'b1) sb_check("done_event", -1);
        end
    end

    initial begin : stim
        rst_i = 1'b1; en = 1'b1; period_tick = 1'b0; tgt_valid = 1'b0;
        tgt_duty = '0; cfg_step = '0; cfg_dwell = '0; abort = 1'b0;
        cyc(3);
        chk("rst_duty", int'(duty_o), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_ready", int'(tgt_ready), 0);
        rst_i = 1'b0;
        cyc(1);
        chk("ready_after_rst", int'(tgt_ready), 1);

        // Basic up-ramp 0 -> 100, step 25
        exp_q.push_back(25); exp_q.push_back(50); exp_q.push_back(75);
        exp_q.push_back(100); exp_q.push_back(-1);
        request(100, 25, 0);
        chk("up_busy", int'(busy), 1);
        send_ticks(4);
        chk("up_busy_end", int'(busy), 0);
        chk("up_ready_end", int'(tgt_ready), 1);

        // Saturating down-ramp with dwell 2
        exp_q.push_back(200); exp_q.push_back(-1);
        request(200, 100, 0);
        send_ticks(1);
        exp_q.push_back(136); exp_q.push_back(72); exp_q.push_back(10); exp_q.push_back(-1);
        request(10, 64, 2);
        send_ticks(9);

        // Target equal to current duty
        exp_q.push_back(50); exp_q.push_back(-1);
        request(50, 40, 0);
        send_ticks(1);
        exp_q.push_back(-1);
        request(50, 5, 0);
        cyc(3);
        chk("equal_duty", int'(duty_o), 50);

        // step=0 behaves as 1
        exp_q.push_back(0); exp_q.push_back(-1);
        request(0, 255, 0);
        send_ticks(1);
        exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(3); exp_q.push_back(-1);
        request(3, 0, 0);
        send_ticks(3);

        // Full-scale target without wrap
        exp_q.push_back(0); exp_q.push_back(-1);
        request(0, 10, 0);
        send_ticks(1);
        exp_q.push_back(200); exp_q.push_back(255); exp_q.push_back(-1);
        request(255, 200, 0);
        send_ticks(2);

        // Pause at 60, resume, then abort on a stepping tick
        exp_q.push_back(0); exp_q.push_back(-1);
        request(0, 255, 0);
        send_ticks(1);
        exp_q.push_back(20); exp_q.push_back(40); exp_q.push_back(60);
        request(120, 20, 1);
        send_ticks(6);
        en = 1'b0;
        send_ticks(5);
        chk("pause_busy", int'(busy), 1);
        en = 1'b1;
        send_ticks(1);
        chk("resume_hold", int'(duty_o), 60);
        exp_q.push_back(80);
        send_ticks(2);
        abort = 1'b1;
        period_tick = 1'b1;
        cyc(1);
        abort = 1'b0;
        period_tick = 1'b0;
        chk("abort_busy", int'(busy), 0);
        chk("abort_duty", int'(duty_o), 80);
        cyc(2);

        // Handshake: valid held while busy, changed target ignored
        exp_q.push_back(85); exp_q.push_back(90); exp_q.push_back(-1);
        exp_q.push_back(200); exp_q.push_back(-1);
        tgt_duty = 8'd90; cfg_step = 8'd5; cfg_dwell = 8'd0;
        tgt_valid = 1'b1;
        cyc(1);
        tgt_duty = 8'd200; cfg_step = 8'd110;
        chk("hs_ready_busy", int'(tgt_ready), 0);
        period_tick = 1'b1; cyc(1); period_tick = 1'b0;
        chk("hs_ready_ramp", int'(tgt_ready), 0);
        period_tick = 1'b1; cyc(1); period_tick = 1'b0;
        cyc(1);
        chk("hs_ready_done", int'(tgt_ready), 0);
        cyc(1);
        chk("hs_ready_idle", int'(tgt_ready), 1);
        cyc(1);
        tgt_valid = 1'b0;
        chk("hs_second_busy", int'(busy), 1);
        send_ticks(1);

        // Asynchronous reset mid-ramp at duty 40
        exp_q.push_back(0); exp_q.push_back(-1);
        request(0, 255, 0);
        send_ticks(1);
        exp_q.push_back(40); exp_q.push_back(0);
        request(100, 40, 0);
        send_ticks(1);
        #2;
        rst_i = 1'b1;
        #1;
        chk("async_rst_duty", int'(duty_o), 0);
        chk("async_rst_busy", int'(busy), 0);
        cyc(2);
        rst_i = 1'b0;
        cyc(1);
        chk("ready_after_async_rst", int'(tgt_ready), 1);

        cyc(5);
        chk("sb_drain", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
